// File: rtl/prime_tester_mr.sv
`default_nettype none
// ============================================================================
// Module   : prime_tester_mr
// Purpose  : Iterative Miller-Rabin primality tester. It takes a candidate n,
//            strips trivial cases, factors n-1 = d*2^s, then runs a number of
//            witness rounds. Each round is a square-and-multiply modexp
//            followed by up to s-1 squarings. Witnesses come either from a
//            free-running LFSR or from a fixed table of small primes.
// Ports    : clk, reset_n (async, active low)
//            start/candidate/rounds/mode  - request, captured in IDLE
//            busy, done (1-cycle pulse), prime, witness, rounds_done
// Revision : 1.0 - initial release
// ============================================================================
module prime_tester_mr #(
    parameter int          WORDSIZE   = 32,
    parameter int          MAX_ROUNDS = 12,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic [WORDSIZE-1:0]                candidate,
    input  logic [$clog2(MAX_ROUNDS+1)-1:0]    rounds,
    input  logic                               mode,
    output logic                               busy,
    output logic                               done,
    output logic                               prime,
    output logic [WORDSIZE-1:0]                witness,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]    rounds_done
);

    localparam int          c_RW          = $clog2(MAX_ROUNDS + 1);
    localparam int          c_SW          = $clog2(WORDSIZE + 1);
    // Random reduction is done at the wider of the LFSR and the word.
    localparam int          c_LW          = (WORDSIZE > 32) ? WORDSIZE : 32;
    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] c_LFSR_TAPS   = 32'h8020_0003;
    localparam int          c_TABLE_LEN   = 12;

    localparam logic [2:0]  c_IDLE    = 3'd0;
    localparam logic [2:0]  c_TRIVIAL = 3'd1;
    localparam logic [2:0]  c_FACTOR  = 3'd2;
    localparam logic [2:0]  c_PICK    = 3'd3;
    localparam logic [2:0]  c_MODEXP  = 3'd4;
    localparam logic [2:0]  c_SQUARE  = 3'd5;
    localparam logic [2:0]  c_NEXT    = 3'd6;
    localparam logic [2:0]  c_DONE    = 3'd7;

    logic [2:0]          r_state;
    logic [WORDSIZE-1:0] r_n;
    logic [WORDSIZE-1:0] r_d;
    logic [WORDSIZE-1:0] r_a;
    logic [WORDSIZE-1:0] r_x;
    logic [WORDSIZE-1:0] r_base;
    logic [WORDSIZE-1:0] r_exp;
    logic [c_SW-1:0]     r_s;
    logic [c_SW-1:0]     r_j;
    logic [31:0]         r_lfsr;
    logic [c_RW-1:0]     r_eff;
    logic                r_mode;
    logic                r_busy;
    logic                r_done;
    logic                r_prime;
    logic [WORDSIZE-1:0] r_witness;
    logic [c_RW-1:0]     r_rounds_done;

    // Full-width product reduced modulo m.
    function automatic logic [WORDSIZE-1:0] f_modmul(
        input logic [WORDSIZE-1:0] x,
        input logic [WORDSIZE-1:0] y,
        input logic [WORDSIZE-1:0] m
    );
        logic [2*WORDSIZE-1:0] p;
        p = {{WORDSIZE{1'b0}}, x} * {{WORDSIZE{1'b0}}, y};
        return WORDSIZE'(p % {{WORDSIZE{1'b0}}, m});
    endfunction

    function automatic logic [7:0] f_table(input logic [c_RW-1:0] k);
        case (int'(k))
            0:       return 8'd2;
            1:       return 8'd3;
            2:       return 8'd5;
            3:       return 8'd7;
            4:       return 8'd11;
            5:       return 8'd13;
            6:       return 8'd17;
            7:       return 8'd19;
            8:       return 8'd23;
            9:       return 8'd29;
            10:      return 8'd31;
            default: return 8'd37;
        endcase
    endfunction

    logic [WORDSIZE-1:0] w_nm1;
    logic [WORDSIZE-1:0] w_mul_xb;
    logic [WORDSIZE-1:0] w_sq_b;
    logic [WORDSIZE-1:0] w_sq_x;
    logic [WORDSIZE-1:0] w_x_step;
    logic [WORDSIZE-1:0] w_rand_a;
    logic [WORDSIZE-1:0] w_tab_a;
    logic [31:0]         w_lfsr_next;
    logic [31:0]         w_req;
    logic [c_RW-1:0]     w_eff;
    logic [c_RW-1:0]     w_rd_inc;

    assign w_nm1       = r_n - WORDSIZE'(1);
    assign w_mul_xb    = f_modmul(r_x, r_base, r_n);
    assign w_sq_b      = f_modmul(r_base, r_base, r_n);
    assign w_sq_x      = f_modmul(r_x, r_x, r_n);
    assign w_x_step    = r_exp[0] ? w_mul_xb : r_x;
    // Odd n >= 5 here, so n-3 >= 2 and the result lands in [2, n-2].
    assign w_rand_a    = WORDSIZE'(c_LW'(r_lfsr) % c_LW'(r_n - WORDSIZE'(3))) + WORDSIZE'(2);
    assign w_tab_a     = WORDSIZE'(f_table(r_rounds_done));
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_LFSR_TAPS) : (r_lfsr >> 1);
    assign w_rd_inc    = r_rounds_done + c_RW'(1);

    // Effective round count: 0 means 1, clamp to MAX_ROUNDS, and the
    // deterministic table caps it further at its length.
    always_comb begin
        w_req = 32'(rounds);
        if (w_req == 32'd0) w_req = 32'd1;
        if (w_req > 32'(MAX_ROUNDS)) w_req = 32'(MAX_ROUNDS);
        if (mode && (w_req > 32'(c_TABLE_LEN))) w_req = 32'(c_TABLE_LEN);
        w_eff = c_RW'(w_req);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_n           <= '0;
            r_d           <= '0;
            r_a           <= '0;
            r_x           <= '0;
            r_base        <= '0;
            r_exp         <= '0;
            r_s           <= '0;
            r_j           <= '0;
            r_lfsr        <= LFSR_SEED;
            r_eff         <= '0;
            r_mode        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_prime       <= 1'b0;
            r_witness     <= '0;
            r_rounds_done <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_n           <= candidate;
                        r_mode        <= mode;
                        r_eff         <= w_eff;
                        r_busy        <= 1'b1;
                        r_prime       <= 1'b0;
                        r_witness     <= '0;
                        r_rounds_done <= '0;
                        r_state       <= c_TRIVIAL;
                    end
                end
                c_TRIVIAL: begin
                    if (r_n < WORDSIZE'(2)) begin
                        r_prime <= 1'b0;
                        r_state <= c_DONE;
                    end else if (r_n < WORDSIZE'(4)) begin
                        r_prime <= 1'b1;
                        r_state <= c_DONE;
                    end else if (!r_n[0]) begin
                        r_prime <= 1'b0;
                        r_state <= c_DONE;
                    end else begin
                        r_d     <= w_nm1;
                        r_s     <= '0;
                        r_state <= c_FACTOR;
                    end
                end
                c_FACTOR: begin
                    if (!r_d[0]) begin
                        r_d <= r_d >> 1;
                        r_s <= r_s + c_SW'(1);
                    end else begin
                        r_state <= c_PICK;
                    end
                end
                c_PICK: begin
                    r_x   <= WORDSIZE'(1);
                    r_exp <= r_d;
                    if (!r_mode) begin
                        r_a     <= w_rand_a;
                        r_base  <= w_rand_a;
                        r_lfsr  <= w_lfsr_next;
                        r_state <= c_MODEXP;
                    end else begin
                        r_a    <= w_tab_a;
                        r_base <= w_tab_a;
                        // A table base at or above n-1 cannot witness anything.
                        r_state <= (w_tab_a >= w_nm1) ? c_NEXT : c_MODEXP;
                    end
                end
                c_MODEXP: begin
                    r_x    <= w_x_step;
                    r_base <= w_sq_b;
                    r_exp  <= r_exp >> 1;
                    // d is odd and nonzero, so exp==1 is the final bit.
                    if (r_exp == WORDSIZE'(1)) begin
                        if ((w_x_step == WORDSIZE'(1)) || (w_x_step == w_nm1)) begin
                            r_state <= c_NEXT;
                        end else if (r_s == c_SW'(1)) begin
                            r_witness     <= r_a;
                            r_prime       <= 1'b0;
                            r_rounds_done <= w_rd_inc;
                            r_state       <= c_DONE;
                        end else begin
                            r_j     <= c_SW'(1);
                            r_state <= c_SQUARE;
                        end
                    end
                end
                c_SQUARE: begin
                    r_x <= w_sq_x;
                    if (w_sq_x == w_nm1) begin
                        r_state <= c_NEXT;
                    end else if ((w_sq_x == WORDSIZE'(1)) || (r_j == (r_s - c_SW'(1)))) begin
                        r_witness     <= r_a;
                        r_prime       <= 1'b0;
                        r_rounds_done <= w_rd_inc;
                        r_state       <= c_DONE;
                    end else begin
                        r_j <= r_j + c_SW'(1);
                    end
                end
                c_NEXT: begin
                    r_rounds_done <= w_rd_inc;
                    if (w_rd_inc == r_eff) begin
                        r_prime <= 1'b1;
                        r_state <= c_DONE;
                    end else begin
                        r_state <= c_PICK;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign prime       = r_prime;
    assign witness     = r_witness;
    assign rounds_done = r_rounds_done;

endmodule
`default_nettype wire

// File: tb/tb_prime_tester_mr.sv
`default_nettype none
// ============================================================================
// Module   : tb_prime_tester_mr
// Purpose  : Self-checking bench for prime_tester_mr. Vectors are applied from
//            a table; expected results go into a queue when a request is
//            driven and are popped when done pulses. Hand-written sequences
//            cover reset state, mid-test reset and start-while-busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prime_tester_mr;

    typedef struct {
        logic        mode;
        logic [31:0] n;
        logic [3:0]  rounds;
        logic        prime;
        logic [31:0] witness;
        logic [3:0]  rd;
        logic        chk_rd;
        logic        w_range;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] candidate;
    logic [3:0]  rounds;
    logic        mode;
    logic        busy;
    logic        done;
    logic        prime;
    logic [31:0] witness;
    logic [3:0]  rounds_done;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_q[$];
    vec_t vecs[16];

    prime_tester_mr dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .candidate   (candidate),
        .rounds      (rounds),
        .mode        (mode),
        .busy        (busy),
        .done        (done),
        .prime       (prime),
        .witness     (witness),
        .rounds_done (rounds_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int bound_of(input vec_t v);
        logic [31:0] d;
        int s;
        int r;
        d = v.n - 32'd1;
        s = 0;
        while (!d[0]) begin
            d = d >> 1;
            s++;
        end
        r = (v.rounds == 4'd0) ? 1 : int'(v.rounds);
        if (r > 12) r = 12;
        return 3 + s + r * (32 + s + 2);
    endfunction

    task automatic start_test(input vec_t v);
        @(negedge clk);
        candidate = v.n;
        rounds    = v.rounds;
        mode      = v.mode;
        start     = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_one(input string tag, input int cyc, input bit ok);
        vec_t e;
        e = exp_q.pop_front();
        if (!ok) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_prime"}, {63'd0, prime}, {63'd0, e.prime});
            check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
            if (e.w_range)
                check({tag, "_witness_range"},
                      ((witness >= 32'd2) && (witness <= e.n - 32'd2)) ? 64'd1 : 64'd0, 64'd1);
            else
                check({tag, "_witness"}, {32'd0, witness}, {32'd0, e.witness});
            if (e.chk_rd)
                check({tag, "_rounds_done"}, {60'd0, rounds_done}, {60'd0, e.rd});
            if ((e.n < 32'd4) || !e.n[0])
                check({tag, "_latency"}, cyc, 2);
            else
                check({tag, "_latency_bound"}, (cyc <= bound_of(e)) ? 64'd1 : 64'd0, 64'd1);
            @(posedge clk);
            #1;
            check({tag, "_done_width"}, {63'd0, done}, 64'd0);
        end
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int cyc;
        bit ok;
        start_test(v);
        wait_done(cyc, ok);
        finish_one(tag, cyc, ok);
    endtask

    initial begin
        int cyc;
        bit ok;
        int pulses;
        vec_t v;

        vecs[0]  = '{1'b1, 32'd97,         4'd4,  1'b1, 32'd0, 4'd4,  1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'd561,        4'd12, 1'b0, 32'd2, 4'd1,  1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'd2,          4'd1,  1'b1, 32'd0, 4'd0,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'd1,          4'd1,  1'b0, 32'd0, 4'd0,  1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'd100,        4'd1,  1'b0, 32'd0, 4'd0,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'd0,          4'd3,  1'b0, 32'd0, 4'd0,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'd3,          4'd2,  1'b1, 32'd0, 4'd0,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'd7,          4'd0,  1'b1, 32'd0, 4'd1,  1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'd5,          4'd3,  1'b1, 32'd0, 4'd3,  1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'd15,         4'd2,  1'b0, 32'd2, 4'd1,  1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'd2047,       4'd5,  1'b0, 32'd3, 4'd2,  1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'd9,          4'd12, 1'b0, 32'd2, 4'd1,  1'b1, 1'b0};
        vecs[12] = '{1'b1, 32'd13,         4'd15, 1'b1, 32'd0, 4'd12, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 32'd4294967291, 4'd8,  1'b1, 32'd0, 4'd8,  1'b1, 1'b0};
        vecs[14] = '{1'b0, 32'd4294967295, 4'd8,  1'b0, 32'd0, 4'd0,  1'b0, 1'b1};
        vecs[15] = '{1'b0, 32'd7,          4'd3,  1'b1, 32'd0, 4'd3,  1'b1, 1'b0};

        reset_n   = 1'b0;
        start     = 1'b0;
        candidate = '0;
        rounds    = '0;
        mode      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",        {63'd0, busy},        64'd0);
        check("reset_done",        {63'd0, done},        64'd0);
        check("reset_prime",       {63'd0, prime},       64'd0);
        check("reset_witness",     {32'd0, witness},     64'd0);
        check("reset_rounds_done", {60'd0, rounds_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_one(vecs[i], $sformatf("v%0d", i));

        // Reset while squaring: 561 with base 2 is in the squaring phase
        // 14 edges after the start is taken.
        v = '{1'b1, 32'd561, 4'd12, 1'b0, 32'd2, 4'd1, 1'b1, 1'b0};
        start_test(v);
        repeat (14) @(posedge clk);
        #1;
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy",        {63'd0, busy},        64'd0);
        check("abort_done",        {63'd0, done},        64'd0);
        check("abort_rounds_done", {60'd0, rounds_done}, 64'd0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
        run_one('{1'b1, 32'd7, 4'd2, 1'b1, 32'd0, 4'd2, 1'b1, 1'b0}, "after_abort");

        // Start pulsed while busy must not disturb the running test.
        start_test(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        candidate = 32'd100;
        rounds    = 4'd1;
        mode      = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, ok);
        finish_one("busy_start", cyc, ok);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("busy_start_ignored", pulses, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prime_tester_mr.md
PRIME_TESTER_MR -- requirements
Module: prime_tester_mr

Interface
REQ-001 Parameter WORDSIZE, default 32: candidate width in bits, legal range 8..64; all modular products computed at 2*WORDSIZE.
REQ-002 Parameter MAX_ROUNDS, default 12: upper bound on witness rounds, sizes the rounds counter.
REQ-003 Parameter LFSR_SEED, default 32'hACE1_2468: nonzero reset value of the internal witness LFSR.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 candidate  input  WORDSIZE  number n under test; captured when start is accepted.
REQ-008 rounds  input  $clog2(MAX_ROUNDS+1)  requested witness count; 0 treated as 1, values above MAX_ROUNDS clamped to MAX_ROUNDS; captured with candidate.
REQ-009 mode  input  1  0 = pseudo-random witnesses from LFSR, 1 = deterministic witness table; captured with candidate.
REQ-010 busy  output  1  high from the cycle after start is accepted until done pulses.
REQ-011 done  output  1  one-cycle pulse when the verdict is valid.
REQ-012 prime  output  1  verdict; holds its value until the next accepted start.
REQ-013 witness  output  WORDSIZE  base that proved compositeness; 0 when prime or when decided trivially.
REQ-014 rounds_done  output  $clog2(MAX_ROUNDS+1)  witness rounds completed, including the failing round.

Function
REQ-015 States: IDLE, TRIVIAL, FACTOR, PICK, MODEXP, SQUARE, NEXT, DONE; encoding is free.
REQ-016 IDLE: start=1 captures inputs, goes to TRIVIAL, raises busy; start=0 keeps IDLE.
REQ-017 TRIVIAL, 1 cycle: n<2 -> composite; n=2 or 3 -> prime; n even and >3 -> composite; each goes to DONE with witness=0 and rounds_done=0. Any other n goes to FACTOR.
REQ-018 FACTOR: d=n-1, s=0; while d[0]=0, shift d right and increment s, one bit per cycle; d odd -> PICK.
REQ-019 PICK, mode 0, 1 cycle: a = 2 + (lfsr mod (n-3)), so a lies in [2, n-2]; the LFSR advances once per pick.
REQ-020 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, free-running only in PICK, never reaches zero; for WORDSIZE>32 the word is zero-extended.
REQ-021 PICK, mode 1: a = table[k] with table {2,3,5,7,11,13,17,19,23,29,31,37}; if a >= n-1 the round counts as passed and goes straight to NEXT. Effective rounds = min(rounds, 12).
REQ-022 MODEXP computes x = a^d mod n by right-to-left square-and-multiply: one exponent bit per cycle; products 2*WORDSIZE wide, reduced mod n every cycle.
REQ-023 After MODEXP: x==1 or x==n-1 -> NEXT; s==1 -> composite; otherwise -> SQUARE with j=1.
REQ-024 SQUARE, one cycle per step: x = x*x mod n. x==n-1 -> NEXT; x==1 -> composite; j==s-1 after the step -> composite; otherwise increment j.
REQ-025 Composite from REQ-023/024: witness=a, prime=0, goes to DONE.
REQ-026 NEXT: increment rounds_done; if rounds_done reaches the effective rounds -> prime=1, DONE; otherwise -> PICK.
REQ-027 DONE: done=1 for exactly one cycle, busy falls in the same cycle, then IDLE; start is ignored while busy.
REQ-028 Latency bound: at most 3 + s + R*(WORDSIZE + s + 2) cycles from start to done, where R is the effective round count.

Reset
REQ-029 reset_n=0 forces state=IDLE, busy=0, done=0, prime=0, witness=0, rounds_done=0, lfsr=LFSR_SEED, regardless of clock.
REQ-030 Reset mid-test abandons it with no done pulse; the first start after release is processed normally.

Verification
REQ-031 mode=1, n=97, rounds=4 -> done with prime=1, rounds_done=4, witness=0.
REQ-032 mode=1, n=561 (Carmichael), rounds=12 -> prime=0, witness=2, rounds_done=1.
REQ-033 n=2 -> prime=1; n=1 -> prime=0; n=100 -> prime=0; each gives done exactly 2 cycles after start with rounds_done=0.
REQ-034 mode=0, n=4294967291, rounds=8 -> prime=1; n=4294967295 -> prime=0 with witness in [2, n-2].
REQ-035 Drop reset_n during SQUARE -> busy=0 with no done pulse; the next start with n=7 -> prime=1.
REQ-036 start pulsed while busy -> ignored; verdict matches the first candidate.
